// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - Access size codes (match funct3[1:0] of RV32 loads/stores).
//   - FSM state encoding for the responder.
//   - lane_mask(): byte-enable pattern for a given size and low address bits.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Little-endian lane enables; an illegal size enables nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
//   req_*  : request channel, valid/ready handshake, address/data/size/signedness
//   rsp_*  : response channel, valid/ready handshake, load data and error flag
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Data RAM: DEPTH_WORDS x 32 bits, per-byte write enables, synchronous write,
// combinational read from the same word index.
//   clk   : write clock
//   we    : byte-lane write enables (bit n writes wdata[8n+7:8n])
//   idx   : word index for both read and write
//   wdata : lane-replicated write data
//   rdata : current contents of word idx
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU load/store port. Accepts one request at a time in IDLE, waits
// LATENCY cycles, then commits the store / samples the load on the edge entering RESP and
// holds the response until the core takes it. Misaligned, out-of-range and size-11 accesses
// are answered with rsp_err=1 and rdata=0 without touching the RAM.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of data_mem_responder_if (req_* in, rsp_* out)
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, unsigned_q;
    logic [31:0]        addr_q, wdata_q;
    logic [1:0]         size_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               in_idle, accept, enter_resp;
    logic               cur_write, cur_unsigned;
    logic [31:0]        cur_addr, cur_wdata;
    logic [1:0]         cur_size;
    logic               acc_err;
    logic [3:0]         mem_we;
    logic [31:0]        mem_wdata, mem_rdata, shifted, load_val;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    assign in_idle    = (state_q == ST_IDLE);
    assign accept     = bus.req_valid & in_idle;
    assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);

    // With LATENCY=0 the commit edge is the accept edge, so the live request is used there.
    assign cur_write    = in_idle ? bus.req_write    : write_q;
    assign cur_addr     = in_idle ? bus.req_addr     : addr_q;
    assign cur_wdata    = in_idle ? bus.req_wdata    : wdata_q;
    assign cur_size     = in_idle ? bus.req_size     : size_q;
    assign cur_unsigned = in_idle ? bus.req_unsigned : unsigned_q;

    assign acc_err = (cur_size == SZ_ILL)
                   | ((cur_size == SZ_HALF) & cur_addr[0])
                   | ((cur_size == SZ_WORD) & (|cur_addr[1:0]))
                   | ({1'b0, cur_addr} >= ADDR_LIMIT);

    // Reset on the commit edge suppresses the write.
    assign mem_we = (enter_resp && cur_write && !acc_err && !reset)
                  ? lane_mask(cur_size, cur_addr[1:0]) : 4'b0000;

    always_comb begin
        case (cur_size)
            SZ_BYTE: mem_wdata = {4{cur_wdata[7:0]}};
            SZ_HALF: mem_wdata = {2{cur_wdata[15:0]}};
            default: mem_wdata = cur_wdata;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Halves are 2-byte aligned when legal, so the byte shift also lines up the half.
    assign shifted = mem_rdata >> {cur_addr[1:0], 3'b000};

    always_comb begin
        case (cur_size)
            SZ_BYTE: load_val = {{24{~cur_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = {{16{~cur_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
        rdata_d = (cur_write || acc_err) ? 32'h0 : load_val;
        err_d   = acc_err;
    end

    // ---------------- request latch and response registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_BYTE;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                write_q    <= bus.req_write;
                unsigned_q <= bus.req_unsigned;
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                size_q     <= bus.req_size;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one LATENCY=2 responder (dut_a) and one LATENCY=0 responder (dut_z)
// sharing the stimulus; sel routes req_valid and the observed outputs to one of them.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_write, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_z ();

    assign bus_a.req_valid    = req_valid & ~sel;
    assign bus_z.req_valid    = req_valid & sel;
    assign bus_a.req_write    = req_write;
    assign bus_z.req_write    = req_write;
    assign bus_a.req_addr     = req_addr;
    assign bus_z.req_addr     = req_addr;
    assign bus_a.req_wdata    = req_wdata;
    assign bus_z.req_wdata    = req_wdata;
    assign bus_a.req_size     = req_size;
    assign bus_z.req_size     = req_size;
    assign bus_a.req_unsigned = req_unsigned;
    assign bus_z.req_unsigned = req_unsigned;
    assign bus_a.rsp_ready    = rsp_ready;
    assign bus_z.rsp_ready    = rsp_ready;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;
    assign o_ready = sel ? bus_z.req_ready : bus_a.req_ready;
    assign o_valid = sel ? bus_z.rsp_valid : bus_a.rsp_valid;
    assign o_err   = sel ? bus_z.rsp_err   : bus_a.rsp_err;
    assign o_rdata = sel ? bus_z.rsp_rdata : bus_a.rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One transaction with rsp_ready=1; lat counts edges from the accept edge (inclusive)
    // until rsp_valid is seen.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
        req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("accept_timeout", {31'b0, o_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = o_rdata;
        er = o_err;
        @(posedge clk); #1;
    endtask

    task automatic chk_txn(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz, input logic u,
                           input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(w, a, d, sz, u, rd, er, lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        logic [7:0] pat;
        logic       stable;
        int         n;

        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_unsigned = 1'b0;
        rsp_ready = 1'b1; req_addr = '0; req_wdata = '0; req_size = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_rsp_rdata", o_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, o_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Word store/load, LATENCY=2
        chk_txn("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 3);
        chk_txn("lw_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 3);

        // Byte/half extension and sub-word store
        chk_txn("lb_13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFFFFDE, 1'b0, 3);
        chk_txn("lbu_13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h000000DE, 1'b0, 3);
        chk_txn("lh_10", 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, 3);
        chk_txn("lhu_12", 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'h0000DEAD, 1'b0, 3);
        chk_txn("sb_11", 1'b1, 32'h11, 32'hFFFFFF55, 2'b00, 1'b0, 32'h0, 1'b0, 3);
        chk_txn("lw_10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD55EF, 1'b0, 3);

        // Errors: none may touch word 0x10 (0x410 aliases its index)
        chk_txn("lw_12_mis", 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 3);
        chk_txn("lh_11_mis", 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 3);
        chk_txn("ld_sz11", 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 3);
        chk_txn("st_sz11", 1'b1, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 3);
        chk_txn("sh_11_mis", 1'b1, 32'h11, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 3);
        chk_txn("sw_400", 1'b1, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 3);
        chk_txn("sw_410", 1'b1, 32'h410, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 3);
        chk_txn("lw_10_after_err", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD55EF, 1'b0, 3);
        chk_txn("sw_3fc", 1'b1, 32'h3FC, 32'h0BADF00D, 2'b10, 1'b0, 32'h0, 1'b0, 3);
        chk_txn("lw_3fc", 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 1'b0, 3);

        // Backpressure: response held 5 cycles while a new request is presented
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h3FC;
        n = 1;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_lat", n, 3);
        chk("bp_rdata", o_rdata, 32'hDEAD55EF);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!(o_valid === 1'b1 && o_rdata === 32'hDEAD55EF && o_err === 1'b0
                  && o_ready === 1'b0)) stable = 1'b0;
        end
        chk("bp_hold", {31'b0, stable}, 32'd1);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_ready", {30'b0, o_ready, o_valid}, 32'b10);
        @(posedge clk); #1;
        chk("bp_next_accepted", {31'b0, o_ready}, 32'd0);
        req_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_next_lat", n, 3);
        chk("bp_next_rdata", o_rdata, 32'h0BADF00D);
        @(posedge clk); #1;

        // LATENCY=0 responder
        sel = 1'b1;
        chk_txn("z_sw_8", 1'b1, 32'h8, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        chk_txn("z_lw_8", 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 1);
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h8; req_size = 2'b10; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            pat[k] = o_valid;
        end
        req_valid = 1'b0;
        chk("z_b2b_pattern", {24'b0, pat}, 32'h55);
        chk("z_b2b_rdata", o_rdata, 32'hCAFEF00D);
        sel = 1'b0;

        // Reset on the commit edge of a store drops it
        chk_txn("sw_20_prior", 1'b1, 32'h20, 32'hA5A5A5A5, 2'b10, 1'b0, 32'h0, 1'b0, 3);
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'b10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready_valid", {30'b0, o_ready, o_valid}, 32'b10);
        @(negedge clk);
        reset = 1'b0;
        chk_txn("lw_20_after_rst", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
